// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace capture buffer.
package trace_pkg;

   localparam int DATA_W_DEF = 33;
   localparam int MAX_ADDR_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4,
      READ  = 3'd5
   } state_t;

   // Callers size-cast the result down to their address width; the low bits wrap naturally.
   function automatic logic [MAX_ADDR_W-1:0] wrap_sub(input logic [MAX_ADDR_W-1:0] a,
                                                      input logic [MAX_ADDR_W-1:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Sample/trigger inputs and readout handshake of the trace buffer.
interface trace_capture_if
   import trace_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic              arm;
   logic [DATA_W-1:0] sample_data;
   logic              trig;
   logic              rd_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              done;
   logic              busy;

   modport master (
      output arm, sample_data, trig, rd_req,
      input  rd_data, rd_valid, rd_last, done, busy
   );

   modport slave (
      input  arm, sample_data, trig, rd_req,
      output rd_data, rd_valid, rd_last, done, busy
   );
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (1-cycle latency).
module capture_ram #(
   parameter int DATA_W = 33,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/trace_capture.sv
// Circular pre/post-trigger capture buffer with oldest-first readout.
module trace_capture
   import trace_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = 8,
   parameter int PRETRIG = 16
) (
   input  logic           clock,
   input  logic           reset,
   trace_capture_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRETRIG - 1);
   localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRETRIG - 2);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;

   logic                we;
   logic                re;
   logic [ADDR_W-1:0]   raddr;
   logic [DATA_W-1:0]   ram_rdata;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      fill_cnt_d   = fill_cnt_q;
      post_cnt_d   = post_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;
      we           = 1'b0;
      re           = 1'b0;
      raddr        = start_addr_q + rd_cnt_q[ADDR_W-1:0];

      case (state_q)
         IDLE: begin
            if (bus.arm) begin
               state_d    = FILL;
               wr_ptr_d   = '0;
               fill_cnt_d = '0;
            end
         end
         FILL: begin
            if (!bus.arm) begin
               state_d = IDLE;
            end else begin
               we         = 1'b1;
               wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
               fill_cnt_d = fill_cnt_q + CNT_W'(1);
               if (fill_cnt_q == FILL_LAST) begin
                  state_d = ARMED;
               end
            end
         end
         ARMED: begin
            // A falling arm wins over a coincident trigger.
            if (!bus.arm) begin
               state_d = IDLE;
            end else begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (bus.trig) begin
                  trig_addr_d = wr_ptr_q;
                  post_cnt_d  = '0;
                  state_d     = POST;
               end
            end
         end
         POST: begin
            if (!bus.arm) begin
               state_d = IDLE;
            end else begin
               we         = 1'b1;
               wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
               post_cnt_d = post_cnt_q + CNT_W'(1);
               if (post_cnt_q == POST_LAST) begin
                  state_d      = DONE;
                  rd_cnt_d     = '0;
                  start_addr_d = ADDR_W'(wrap_sub(MAX_ADDR_W'(trig_addr_q),
                                                  MAX_ADDR_W'(PRETRIG)));
               end
            end
         end
         DONE, READ: begin
            if (bus.rd_req) begin
               re       = 1'b1;
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
               state_d  = (rd_cnt_q == RD_LAST) ? IDLE : READ;
            end
         end
         default: state_d = IDLE;
      endcase

      rd_valid_d = re;
      rd_last_d  = re && (rd_cnt_q == RD_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         data_q       <= '0;
         wr_ptr_q     <= '0;
         fill_cnt_q   <= '0;
         post_cnt_q   <= '0;
         rd_cnt_q     <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= bus.sample_data;
         wr_ptr_q     <= wr_ptr_d;
         fill_cnt_q   <= fill_cnt_d;
         post_cnt_q   <= post_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_q),
      .re_i    (re),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   // The RAM output register is not reset, so hold rd_data at zero between words.
   assign bus.rd_data  = rd_valid_q ? ram_rdata : '0;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_last  = rd_last_q;
   assign bus.busy     = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
   assign bus.done     = (state_q == DONE) || (state_q == READ);
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture (DEPTH=16, PRETRIG=4) with a readout scoreboard.
module tb_trace_capture;
   localparam int DW    = 33;
   localparam int AW    = 4;
   localparam int PT    = 4;
   localparam int DEPTH = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;

   trace_capture_if #(.DATA_W(DW)) bus ();

   trace_capture #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .PRETRIG (PT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every readout word must match the oldest pending expectation; no word may appear unannounced.
   task automatic observe();
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("rd_valid", 64'(bus.rd_valid), 64'd1);
         check("rd_data", 64'(bus.rd_data), 64'(e.data));
         check("rd_last", 64'(bus.rd_last), 64'(e.last));
      end else begin
         check("rd_valid_quiet", 64'(bus.rd_valid), 64'd0);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      observe();
   endtask

   // Samples are base+t; trig follows sample trig_at, optional early trig follows sample early_at.
   task automatic capture(input int base, input int trig_at, input int early_at, input int abort_after);
      for (int t = 0; t <= trig_at + 12; t++) begin
         bus.arm         = 1'b1;
         bus.sample_data = DW'(base + t);
         bus.trig        = (t == trig_at + 1) || (early_at >= 0 && t == early_at + 1);
         if (abort_after >= 0 && t == trig_at + 2 + abort_after) begin
            bus.arm  = 1'b0;
            bus.trig = 1'b0;
            tick();
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_done", 64'(bus.done), 64'd0);
            return;
         end
         tick();
         if (abort_after >= 0 && t == trig_at + 1 + abort_after)
            check("post_busy", 64'(bus.busy), 64'd1);
         if (t == trig_at + 11) begin
            check("pre_done", 64'(bus.done), 64'd0);
            check("pre_busy", 64'(bus.busy), 64'd1);
         end
         if (t == trig_at + 12) begin
            check("capture_done", 64'(bus.done), 64'd1);
            check("capture_busy", 64'(bus.busy), 64'd0);
         end
      end
      bus.arm  = 1'b0;
      bus.trig = 1'b0;
   endtask

   task automatic readout(input int first, input int n_req, input bit gap);
      for (int i = 0; i < n_req; i++) begin
         bus.rd_req = 1'b1;
         if (i < DEPTH)
            sb.push_back('{data: DW'(first + i), last: (i == DEPTH - 1)});
         tick();
         if (i == 0)
            check("done_in_read", 64'(bus.done), 64'd1);
         if (i == DEPTH - 1) begin
            check("done_at_last", 64'(bus.done), 64'd0);
            check("busy_at_last", 64'(bus.busy), 64'd0);
         end
         if (gap) begin
            bus.rd_req = 1'b0;
            tick();
         end
      end
      bus.rd_req = 1'b0;
      tick();
   endtask

   initial begin
      bus.arm         = 1'b0;
      bus.sample_data = '0;
      bus.trig        = 1'b0;
      bus.rd_req      = 1'b0;
      reset           = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("reset_rd_last", 64'(bus.rd_last), 64'd0);
      check("reset_rd_data", 64'(bus.rd_data), 64'd0);
      reset = 1'b0;

      // rd_req while idle is ignored
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();

      // Basic capture: trigger on sample 20, spaced reads of 16..31
      capture(0, 20, -1, -1);
      readout(16, 16, 1'b1);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();
      check("idle_done", 64'(bus.done), 64'd0);
      check("idle_busy", 64'(bus.busy), 64'd0);

      // Early trigger during FILL ignored; real trigger on sample 9 -> trace 5..20
      capture(0, 9, 1, -1);
      readout(5, 16, 1'b0);

      // Trigger at address 2 -> start address 14; back-to-back with extra requests
      capture(0, 18, -1, -1);
      readout(14, 18, 1'b0);

      // Abort after 3 post samples; later rd_req yields nothing
      capture(0, 20, -1, 3);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();
      check("abort_idle_done", 64'(bus.done), 64'd0);

      // Reset after 7 words, then a fresh capture with different data
      capture(0, 20, -1, -1);
      readout(16, 7, 1'b0);
      reset      = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      check("rst_read_done", 64'(bus.done), 64'd0);
      check("rst_read_busy", 64'(bus.busy), 64'd0);
      reset      = 1'b0;
      bus.rd_req = 1'b0;
      tick();
      capture(100, 7, -1, -1);
      readout(103, 16, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Sample buffer downstream of the trigger/match stage in the analyzer pipeline.
- While armed, continuously records the analyzer input bus into a circular RAM.
- On the single-cycle match pulse from the trigger stage, keeps PRETRIG samples before the trigger and fills the rest of the buffer with post-trigger samples.
- Then streams the whole trace, oldest sample first, to the readout logic on request.

Parameters:
- DATA_W, 33, width of the sampled bus; matches the trigger stage data width.
- ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W samples.
- PRETRIG, 16, number of samples kept before the trigger sample; legal range 1..DEPTH-2.

Ports:
- clock  in  1  sample clock, shared with the trigger stage.
- reset  in  1  synchronous, active-high.
- arm  in  1  level; 1 = capture enabled. Driven from the same source as the trigger stage start input.
- sample_data  in  DATA_W  raw analyzer bus, the same bus the trigger stage compares.
- trig  in  1  registered match pulse from the trigger stage.
- rd_req  in  1  one-cycle request for the next trace word.
- rd_data  out  DATA_W  trace word.
- rd_valid  out  1  rd_data valid; 1-cycle pulse.
- rd_last  out  1  asserted with rd_valid on the final (DEPTH-th) word.
- done  out  1  capture complete, trace available.
- busy  out  1  high in FILL, ARMED and POST.

Behaviour:
- Interface: one clock, `clock`; synchronous active-high `reset`.
- Reset: all outputs 0, state IDLE, pointers and counters 0. Reset wins over every other input in any state, including mid-capture and mid-readout. RAM contents are not cleared.
- Alignment:
  - trig arrives one cycle after the sample that matched.
  - sample_data passes through one internal register (data_d); all RAM writes use data_d.
  - The sample written in the cycle trig=1 is therefore the matching sample.
- IDLE: no writes. arm=1 -> FILL with wr_ptr=0, fill_cnt=0.
- FILL:
  - Each cycle, write data_d at wr_ptr, then increment wr_ptr and fill_cnt.
  - trig is ignored.
  - After PRETRIG writes -> ARMED.
- ARMED:
  - Each cycle, write at wr_ptr; wr_ptr wraps modulo DEPTH.
  - trig=1: the current write is the trigger sample. Latch trig_addr=wr_ptr, clear post_cnt -> POST.
- POST:
  - Each cycle, write and increment post_cnt; trig is ignored.
  - After DEPTH-PRETRIG-1 post writes -> DONE.
  - Latch start_addr = (trig_addr - PRETRIG) mod DEPTH, computed in ADDR_W bits with natural wrap.
- Abort: arm=0 in FILL, ARMED or POST -> IDLE next cycle. No write in that cycle; done stays 0.
- Simultaneous events: arm falling in the same cycle as trig in ARMED is treated as an abort (abort wins).
- DONE:
  - done=1; arm is ignored.
  - rd_req=1 -> READ and issue the first RAM read at start_addr; rd_cnt=0.
- READ:
  - Each rd_req issues a RAM read at rd_addr = start_addr + rd_cnt (wraps) and increments rd_cnt.
  - rd_data and rd_valid appear exactly 1 cycle after the rd_req.
  - rd_req in the cycle rd_valid is high is legal, giving back-to-back reads at 1 word/cycle.
  - rd_last accompanies the DEPTH-th word. The state goes to IDLE in the cycle that word is output, and done clears in that same cycle.
  - rd_req outside DONE/READ is ignored; rd_valid stays 0.
- busy = (state is FILL, ARMED or POST); done = (state is DONE or READ).
- Widths: fill_cnt, post_cnt and rd_cnt are ADDR_W+1 bits so that a count of DEPTH is representable. No overflow is possible within a capture.

Decomposition:
- Package trace_pkg holds:
  - state encoding: IDLE, FILL, ARMED, POST, DONE, READ (3 bits);
  - DATA_W default;
  - helper function for the modular subtraction used for start_addr.
- Sub-module capture_ram:
  - simple dual-port RAM, one write port and one registered synchronous read port, 1-cycle latency;
  - parameterised by DATA_W and ADDR_W.
- trace_capture holds only the FSM, pointers and the input register.

Test Plan (bench uses ADDR_W=4, so DEPTH=16, and PRETRIG=4):
- Basic capture:
  - Stimulus: reset, then arm=1 with sample_data = cycle count 0,1,2,…; trig 1 cycle after sample 20 appears.
  - Response: done=1 after 11 post samples.
  - Readout: 16 rd_req give 16,17,18,19,20,…,31; rd_last on 31; state IDLE afterwards.
- Early trigger:
  - Stimulus: trig pulses during FILL (e.g. after sample 1), then a second trig after sample 9.
  - Response: first pulse ignored; trace holds 5..20 with trigger at index 4 (value 9).
- Wrap of start_addr:
  - Stimulus: trigger lands at wr_ptr=2.
  - Response: start_addr=14; readout order is RAM addresses 14,15,0,…,13; data continuous.
- Abort:
  - Stimulus: arm drops in POST after 3 post samples.
  - Response: next cycle IDLE, busy=0, done=0; a subsequent rd_req gives rd_valid=0.
- Reset mid-readout:
  - Stimulus: reset after 7 words have been read.
  - Response: next cycle rd_valid=0, done=0, IDLE; re-arming produces a fresh capture.
- Back-to-back read:
  - Stimulus: rd_req held high for 16 cycles.
  - Response: rd_valid high for 16 consecutive cycles starting 1 cycle after the first request; extra requests after the 16th are ignored.
